// File: rtl/result_display_driver.sv
// Binary-to-BCD converter (sequential double-dabble) driving a time-multiplexed,
// active-low 7-segment display. bcd_out only updates once a conversion completes.
module result_display_driver #(
    parameter int IN_W        = 8,
    parameter int DIGITS      = 3,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_W-1:0]       bin_in,
    input  logic                  bin_valid,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int CNT_W  = $clog2(IN_W + 1);
    localparam int SCAN_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [IN_W-1:0]     r_shift;
    logic [BCD_W-1:0]    r_scratch;
    logic [BCD_W-1:0]    r_bcd;
    logic [BCD_W-1:0]    w_adj;

    logic [SCAN_W-1:0]   r_scan_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [DIGITS-1:0]   r_an;
    logic [6:0]          r_seg;
    logic [DIGITS-1:0]   w_an;
    logic [6:0]          w_seg;
    logic [3:0]          w_nib;

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Digit idx is a leading zero when it and every more-significant nibble are 0.
    function automatic logic lead_zero(input logic [BCD_W-1:0] b, input logic [IDX_W-1:0] idx);
        logic z;
        z = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (i >= int'(idx) && b[i*4 +: 4] != 4'd0)
                z = 1'b0;
        end
        return z && (idx != '0);
    endfunction

    assign w_adj = add3(r_scratch);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bin_valid) w_next_state = CONVERT;
            CONVERT: if (r_bit_cnt == CNT_W'(1)) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_bcd     <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE:    if (bin_valid) r_bit_cnt <= CNT_W'(IN_W);
                CONVERT: r_bit_cnt <= r_bit_cnt - 1'b1;
                DONE:    r_bcd <= r_scratch;
                default: ;
            endcase
        end
    end

    // Conversion datapath carries no reset; its contents only matter once the FSM has loaded it.
    always_ff @(posedge clk) begin
        case (r_state)
            IDLE: begin
                if (bin_valid) begin
                    r_shift   <= bin_in;
                    r_scratch <= '0;
                end
            end
            CONVERT: {r_scratch, r_shift} <= {w_adj, r_shift} << 1;
            default: ;
        endcase
    end

    assign w_nib = r_bcd[r_idx*4 +: 4];

    always_comb begin
        w_an        = '1;
        w_an[r_idx] = 1'b0;
        w_seg       = seg7(w_nib);
        if (BLANK_LZ != 0 && lead_zero(r_bcd, r_idx))
            w_seg = 7'b1111111;
    end

    // Scan runs free of the FSM; seg/an lag the index by one register stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_an       <= ~DIGITS'(1);
            r_seg      <= 7'b1000000;
        end else begin
            if (r_scan_cnt == SCAN_LAST) begin
                r_scan_cnt <= '0;
                r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            r_an  <= w_an;
            r_seg <= w_seg;
        end
    end

    assign busy    = (r_state != IDLE);
    assign bcd_out = r_bcd;
    assign seg     = r_seg;
    assign an      = r_an;

endmodule

// File: tb/tb_result_display_driver.sv
// Scoreboard bench for result_display_driver: loads push expected BCD, a monitor
// pops and compares on each busy falling edge; display and scan are checked directly.
module tb_result_display_driver;

    localparam int IN_W   = 8;
    localparam int DIGITS = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [IN_W-1:0]     bin_in = '0;
    logic                bin_valid = 1'b0;
    logic                busy;
    logic [4*DIGITS-1:0] bcd_out;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;

    int n_checks = 0;
    int n_errors = 0;
    logic [11:0] exp_q[$];

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S4 = 7'b0011001, S5 = 7'b0010010, SB = 7'b1111111;

    result_display_driver #(.IN_W(IN_W), .DIGITS(DIGITS), .REFRESH_DIV(4), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .bin_in(bin_in), .bin_valid(bin_valid),
        .busy(busy), .bcd_out(bcd_out), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a completed conversion is signalled by busy falling while out of reset.
    initial begin
        logic prev_busy;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_result: got 0x%0h expected none", bcd_out);
                end else begin
                    chk("bcd_out", {20'd0, bcd_out}, {20'd0, exp_q.pop_front()});
                end
            end
            prev_busy = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_idle(input string name, output int cycles);
        cycles = 0;
        while (busy && cycles < 30) begin
            cycles++;
            @(negedge clk);
        end
        if (busy) chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic load(input logic [7:0] v, input logic [11:0] exp_bcd, output int cycles);
        @(negedge clk);
        bin_in    = v;
        bin_valid = 1'b1;
        exp_q.push_back(exp_bcd);
        @(negedge clk);
        bin_valid = 1'b0;
        wait_idle("load", cycles);
    endtask

    task automatic check_display(input string name, input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2);
        logic [6:0] e;
        repeat (2) @(negedge clk);
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            case (an)
                3'b110:  e = e0;
                3'b101:  e = e1;
                3'b011:  e = e2;
                default: e = 7'bx;
            endcase
            if (e === 7'bx) chk({name, "_an_onehot"}, {29'd0, an}, 32'h6);
            else            chk({name, "_seg"}, {25'd0, seg}, {25'd0, e});
        end
    endtask

    initial begin
        int cyc;
        logic [2:0] prev_an;
        logic [2:0] pat [3];
        pat[0] = 3'b110; pat[1] = 3'b101; pat[2] = 3'b011;

        // Reset
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_bcd", {20'd0, bcd_out}, 32'd0);
        chk("rst_an", {29'd0, an}, 32'h6);
        chk("rst_seg", {25'd0, seg}, {25'd0, S0});
        rst = 1'b1;

        // Scan wrap: find the first cycle of an=110 then follow 13 cycles
        prev_an = an;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (an == 3'b110 && prev_an != 3'b110) break;
            prev_an = an;
        end while (cyc < 40);
        chk("scan_sync", {31'd0, (cyc < 40)}, 32'd1);
        for (int t = 0; t < 13; t++) begin
            chk("scan_an", {29'd0, an}, {29'd0, pat[(t / 4) % 3]});
            @(negedge clk);
        end

        // Load 5
        load(8'd5, 12'h005, cyc);
        chk("busy_cycles", cyc, 32'd9);
        check_display("d5", S5, SB, SB);

        // Load 255
        load(8'd255, 12'h255, cyc);
        check_display("d255", S5, S5, S2);

        // Load 100, then an ignored strobe of 7 while busy
        @(negedge clk);
        bin_in = 8'd100; bin_valid = 1'b1;
        exp_q.push_back(12'h100);
        @(negedge clk);
        bin_valid = 1'b0;
        repeat (2) @(negedge clk);
        bin_in = 8'd7; bin_valid = 1'b1;
        chk("busy_at_e3", {31'd0, busy}, 32'd1);
        @(negedge clk);
        bin_valid = 1'b0;
        wait_idle("load100", cyc);
        repeat (3) begin
            @(negedge clk);
            chk("no_requeue", {31'd0, busy}, 32'd0);
        end
        chk("bcd_100", {20'd0, bcd_out}, 32'h100);
        check_display("d100", S0, S0, S1);

        // Reset in the middle of a load of 200
        @(negedge clk);
        bin_in = 8'd200; bin_valid = 1'b1;
        @(negedge clk);
        bin_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_bcd", {20'd0, bcd_out}, 32'd0);
        chk("abort_an", {29'd0, an}, 32'h6);
        chk("abort_seg", {25'd0, seg}, {25'd0, S0});
        repeat (2) @(negedge clk);
        rst = 1'b1;
        load(8'd42, 12'h042, cyc);
        check_display("d42", S2, S4, SB);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
